// File: rtl/ripple_down_counter_t_ff.sv
// Rising-edge toggle flip-flop with asynchronous active-low clear.
// One stage of the ripple chain in ripple_down_counter.
module t_ff (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q,
    output logic q_bar
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

    assign q_bar = ~q;

endmodule

// File: rtl/ripple_down_counter.sv
// Ripple down counter built from a chain of T flip-flops, with a clk-domain
// observation stage so synchronous logic never samples the rippling chain.
module ripple_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             t,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] q_sync,
    output logic             zero,
    output logic             underflow
);

    logic [WIDTH-1:0] stage_clk;
    logic [WIDTH-1:0] stage_t;

    // A rising edge on bit i-1 means it went 0->1, i.e. a borrow out of the
    // lower bits, so the next stage toggles: the chain counts down.
    assign stage_clk = {q[WIDTH-2:0], clk};
    assign stage_t   = {{(WIDTH-1){1'b1}}, t};

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        t_ff u_stage (
            .clk   (stage_clk[i]),
            .rst_n (rst_n),
            .t     (stage_t[i]),
            .q     (q[i]),
            .q_bar (q_bar[i])
        );
    end

    // Samples the settled pre-edge value; stage 0 updates in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sync    <= '0;
            zero      <= 1'b1;
            underflow <= 1'b0;
        end else begin
            q_sync    <= q;
            zero      <= (q == '0);
            underflow <= (q == '0) && t;
        end
    end

endmodule

// File: tb/tb_ripple_down_counter.sv
// Scoreboard bench for ripple_down_counter: random and directed enable patterns
// checked against an integer count-down model; a WIDTH=8 instance checks wrap.
module tb_ripple_down_counter;

    localparam int W = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         t;
    logic [W-1:0] q, q_bar, q_sync;
    logic         zero, underflow;

    logic         rst8_n;
    logic         t8;
    logic [7:0]   q8, q8_bar, q8_sync;
    logic         zero8, underflow8;

    int n_vec = 0;
    int n_bad = 0;
    int cnt   = 0;   // reference model: current count of the W-bit counter

    typedef struct {
        int q;
        int q_sync;
        int zero;
        int uf;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ripple_down_counter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .t(t), .q(q), .q_bar(q_bar),
        .q_sync(q_sync), .zero(zero), .underflow(underflow)
    );

    ripple_down_counter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .t(t8), .q(q8), .q_bar(q8_bar),
        .q_sync(q8_sync), .zero(zero8), .underflow(underflow8)
    );

    function automatic void check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // One clk edge of stimulus: set t before the edge, predict the outputs after it.
    task automatic drive(input logic t_val);
        exp_t e;
        @(negedge clk);
        t = t_val;
        e.q_sync = cnt;
        e.zero   = (cnt == 0) ? 1 : 0;
        e.uf     = (cnt == 0 && t_val) ? 1 : 0;
        if (t_val) cnt = (cnt + MOD - 1) % MOD;
        e.q = cnt;
        sb.push_back(e);
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 2 * MOD && cnt != target; i++) drive(1'b1);
        check("run_to_reached", cnt, target);
    endtask

    // Monitor: pops one prediction per edge for which stimulus issued one.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("q",         int'(q),         e.q);
            check("q_bar",     int'(q_bar),     (~e.q) & (MOD - 1));
            check("q_sync",    int'(q_sync),    e.q_sync);
            check("zero",      int'(zero),      e.zero);
            check("underflow", int'(underflow), e.uf);
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        rst_n  = 1'b0;
        rst8_n = 1'b0;
        t      = 1'b0;
        t8     = 1'b0;
        #12;
        check("rst_q",         int'(q),         0);
        check("rst_q_bar",     int'(q_bar),     MOD - 1);
        check("rst_q_sync",    int'(q_sync),    0);
        check("rst_zero",      int'(zero),      1);
        check("rst_underflow", int'(underflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;

        // ten enabled edges then four frozen ones
        for (int i = 0; i < 10; i++) drive(1'b1);
        check("after10", cnt, 6);
        for (int i = 0; i < 4; i++) drive(1'b0);

        // through 0001 -> 0000 -> 1111 wrap, plus two edges beyond
        run_to(1);
        drive(1'b1);
        drive(1'b1);
        drive(1'b1);
        drive(1'b0);

        // t dropped 1 ns after the edge that starts the 1000 -> 0111 ripple
        run_to(8);
        drive(1'b1);
        @(posedge clk);
        #1 t = 1'b0;
        #2;
        check("ripple_complete", int'(q), 7);
        drive(1'b0);

        // reset mid-count, between edges
        run_to(5);
        drive(1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_q",         int'(q),         0);
        check("midrst_q_bar",     int'(q_bar),     MOD - 1);
        check("midrst_q_sync",    int'(q_sync),    0);
        check("midrst_zero",      int'(zero),      1);
        check("midrst_underflow", int'(underflow), 0);
        t = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("held_rst_q", int'(q), 0);
        @(negedge clk);
        t = 1'b0;
        rst_n = 1'b1;
        cnt = 0;
        drive(1'b1);
        @(posedge clk);
        #2;
        check("first_after_rst", int'(q), MOD - 1);

        for (int i = 0; i < 300; i++) drive(1'($urandom_range(0, 1)));
        drive(1'b0);
        @(posedge clk);
        #2;
        check("sb_drained", sb.size(), 0);

        // WIDTH=8: 256 enabled edges from reset wrap exactly once
        pulses = 0;
        @(negedge clk);
        rst8_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            t8 = 1'b1;
            @(posedge clk);
            #1;
            if (underflow8) pulses++;
        end
        @(negedge clk);
        t8 = 1'b0;
        check("w8_underflow_pulses", pulses, 1);
        check("w8_q_returns_zero",   int'(q8), 0);
        check("w8_q_bar",            int'(q8_bar), 255);
        @(posedge clk);
        #1;
        check("w8_zero", int'(zero8), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ripple_down_counter.md
# ripple_down_counter

Parameterised asynchronous (ripple) down counter built from a chain of T flip-flops, plus a clock-synchronous observation stage. It is the count-down counterpart of the team's ripple up counter, with the same `t` enable and `q`/`q_bar` outputs. It also adds registered `q_sync`, `zero` and `underflow` outputs, so downstream synchronous logic never samples the rippling chain directly.

## Interface
- `WIDTH`, default 4: number of ripple stages / counter bits (≥ 2).
- `clk`  input  1  system clock; drives stage 0 and the observation registers.
- `rst_n`  input  1  asynchronous, active-low reset.
- `t`  input  1  count enable; gates stage 0 only.
- `q`  output  WIDTH  raw ripple-chain value (asynchronous, settles after the ripple).
- `q_bar`  output  WIDTH  bitwise complement of `q` at all times.
- `q_sync`  output  WIDTH  `q` as sampled on each `clk` rising edge (one-cycle lag).
- `zero`  output  1  registered flag: `q` was 0 at the last `clk` rising edge.
- `underflow`  output  1  one-cycle pulse: counter wrapped from 0 to all-ones on this edge.

## Operation
- Stage 0 toggles on `clk` rising edge when `t`=1 and holds when `t`=0.
- Stage i (i≥1) toggles on every rising edge of `q[i-1]`, with its T input tied to 1. Net effect is a decrement by 1 per enabled `clk` edge.
- Once started, a ripple always completes. Deasserting `t` mid-ripple never truncates it.
- Sequence for WIDTH=4 from reset: 0000 → 1111 → 1110 → … → 0001 → 0000 → 1111 (modulo 2^WIDTH wrap).
- Observation registers, all on `clk` rising edge, sampling the pre-edge (settled) `q`:
  - `q_sync` ← `q`.
  - `zero` ← (`q` == 0).
  - `underflow` ← (`q` == 0) && `t`. This is high for exactly the cycle in which the chain wraps to all-ones.
- Reset (`rst_n`=0), asynchronous, dominates everything:
  - All stages go to 0 and `q_bar` = all-ones.
  - `q_sync` = 0, `zero` = 1, `underflow` = 0.
  - Falling `q` bits during reset create no rising edges, so no spurious toggles occur.
- Reset mid-ripple: the chain is forced to 0 immediately. The first enabled edge after release yields all-ones.
- Reset release coincident with a `clk` edge: stage 0 does not toggle on that edge.

## Timing
- `q` bit 0 changes at the `clk` edge. Bit i settles after i flip-flop delays, with zero delay in RTL simulation.
- `q` may be transiently invalid during the ripple. Only `q_sync`, `zero` and `underflow` are safe for synchronous consumers.
- Latency: `q_sync` reflects the count after edge k at edge k+1, i.e. 1 cycle.
- The `underflow` pulse aligns with the edge at which `q_sync` still shows 0. The following edge shows `q_sync` = all-ones.
- `t` is sampled only at `clk` rising edges. Glitches between edges have no effect.
- Settling constraint: WIDTH × t_clk→q + setup < clock period. At WIDTH=4 this is met by the 10 ns bench clock.

## Structure
- Sub-module `t_ff`:
  - Ports: `clk`, `rst_n`, `t`, `q`, `q_bar`.
  - Rising-edge triggered T flip-flop with asynchronous active-low clear.
  - Instantiated WIDTH times via generate. Stage i>0 is clocked by `q[i-1]`.
- Observation registers live in the top level.
- No shared package needed. WIDTH is the only constant and stays a module parameter.

## Test plan
- Reset then `t`=1 for 100 ns (10 edges, WIDTH=4) → `q` steps 1111, 1110, …, 0110. `q_bar` is always the complement, and `q_sync` lags one cycle.
- `t`=0 for 40 ns → `q`, `q_sync` frozen. `zero`=0 and `underflow`=0 throughout.
- `t`=1 from `q`=0001 → the next edge gives `q`=0000 and `zero`=1 one edge later. The next edge gives `q`=1111 with `underflow`=1 for exactly one cycle and `q_sync`=0000. Then `q_sync`=1111.
- Toggle `t` low 1 ns after the edge that starts the 1000→0111 ripple → the ripple completes and `q`=0111, not a partial value.
- Assert `rst_n`=0 mid-count (`q`=0101, between edges) → `q`=0000, `q_bar`=1111, `q_sync`=0, `zero`=1 and `underflow`=0 immediately. The first enabled edge after release gives `q`=1111.
- WIDTH=8, `t`=1 for 256 edges from reset → exactly one `underflow` pulse, and `q` returns to 0x00.
